// File: rtl/mem_request_initiator.sv
// Memory request initiator: issues a configurable run of SRAM/DRAM requests,
// tracks outstanding requests in an in-order tag FIFO, and gathers per-request
// latency statistics and error flags from the response stream.
module mem_request_initiator #(
  parameter int SIZE_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           cfg_num_reqs,
  input  logic [SIZE_WIDTH-1:0] cfg_size_bytes,
  input  logic [3:0]            cfg_dram_every,
  input  logic [7:0]            cfg_gap_cycles,
  output logic                  req_valid,
  output logic                  req_is_dram,
  output logic [SIZE_WIDTH-1:0] req_size_bytes,
  input  logic                  req_ready,
  input  logic                  resp_valid,
  input  logic [SIZE_WIDTH-1:0] resp_size_bytes,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           issued_count,
  output logic [15:0]           completed_count,
  output logic [4:0]            outstanding,
  output logic [31:0]           lat_min,
  output logic [31:0]           lat_max,
  output logic [31:0]           lat_sum,
  output logic                  err_unexpected_resp,
  output logic                  err_size_mismatch
);

  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [4:0]    MAX_OUT  = 5'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST_PTR = PW'(MAX_OUTSTANDING - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, GAP, DRAIN, DONE} state_t;

  state_t state_q, state_d;
  logic [7:0] gapCnt_q, gapCnt_d;

  logic [15:0]           numReqs_q;
  logic [SIZE_WIDTH-1:0] sizeBytes_q;
  logic [3:0]            dramEvery_q;
  logic [7:0]            gapCycles_q;
  logic [3:0]            dramPhase_q;
  logic [31:0]           cycle_q;

  logic [31:0]           stampMem_q [MAX_OUTSTANDING];
  logic [SIZE_WIDTH-1:0] sizeMem_q  [MAX_OUTSTANDING];
  logic [PW-1:0]         wrPtr_q, rdPtr_q;
  logic [4:0]            count_q;

  logic                  startAccept;
  logic                  handshake;
  logic                  pop;
  logic [31:0]           headStamp;
  logic [SIZE_WIDTH-1:0] headSize;
  logic [31:0]           latency;
  logic [32:0]           sumWide;

  // Handshake/pop qualifiers, FIFO head view and the outgoing request fields.
  // dramPhase_q holds (issued_count mod dram_every), so the next request is
  // DRAM when the phase is one short of wrapping.
  always_comb begin
    startAccept    = start && ((state_q == IDLE) || (state_q == DONE));
    req_valid      = (state_q == ISSUE) && (count_q < MAX_OUT);
    req_is_dram    = (dramEvery_q != 4'd0) && (dramPhase_q == (dramEvery_q - 4'd1));
    req_size_bytes = sizeBytes_q;
    handshake      = req_valid && req_ready;
    pop            = resp_valid && (count_q != 5'd0);
    headStamp      = stampMem_q[rdPtr_q];
    headSize       = sizeMem_q[rdPtr_q];
    latency        = cycle_q - headStamp;
    sumWide        = {1'b0, lat_sum} + {1'b0, latency};
    busy           = (state_q == ISSUE) || (state_q == GAP) || (state_q == DRAIN);
    done           = (state_q == DONE);
    outstanding    = count_q;
  end

  // Run sequencing: next state and gap countdown.
  always_comb begin
    state_d  = state_q;
    gapCnt_d = gapCnt_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) state_d = (cfg_num_reqs == 16'd0) ? DONE : ISSUE;
      end
      ISSUE: begin
        if (handshake) begin
          if ((issued_count + 16'd1) == numReqs_q) begin
            state_d = DRAIN;
          end else if (gapCycles_q != 8'd0) begin
            state_d  = GAP;
            gapCnt_d = gapCycles_q;
          end
        end
      end
      GAP: begin
        if (gapCnt_q <= 8'd1) state_d = ISSUE;
        else gapCnt_d = gapCnt_q - 8'd1;
      end
      DRAIN: begin
        if (count_q == 5'd0) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register for the run sequencer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      gapCnt_q <= 8'd0;
    end else begin
      state_q  <= state_d;
      gapCnt_q <= gapCnt_d;
    end
  end

  // Configuration latch, run counters, latency statistics and sticky errors.
  // A start clears the statistics and takes priority over a same-cycle pop's
  // statistics update; the pop itself still retires the FIFO entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_q             <= 32'd0;
      numReqs_q           <= 16'd0;
      sizeBytes_q         <= '0;
      dramEvery_q         <= 4'd0;
      gapCycles_q         <= 8'd0;
      dramPhase_q         <= 4'd0;
      issued_count        <= 16'd0;
      completed_count     <= 16'd0;
      lat_min             <= 32'hFFFF_FFFF;
      lat_max             <= 32'd0;
      lat_sum             <= 32'd0;
      err_unexpected_resp <= 1'b0;
      err_size_mismatch   <= 1'b0;
    end else begin
      cycle_q <= cycle_q + 32'd1;
      if (startAccept) begin
        numReqs_q           <= cfg_num_reqs;
        sizeBytes_q         <= cfg_size_bytes;
        dramEvery_q         <= cfg_dram_every;
        gapCycles_q         <= cfg_gap_cycles;
        dramPhase_q         <= 4'd0;
        issued_count        <= 16'd0;
        completed_count     <= 16'd0;
        lat_min             <= 32'hFFFF_FFFF;
        lat_max             <= 32'd0;
        lat_sum             <= 32'd0;
        err_unexpected_resp <= 1'b0;
        err_size_mismatch   <= 1'b0;
      end else begin
        if (handshake) begin
          issued_count <= issued_count + 16'd1;
          if ((dramEvery_q == 4'd0) || (dramPhase_q == (dramEvery_q - 4'd1))) dramPhase_q <= 4'd0;
          else dramPhase_q <= dramPhase_q + 4'd1;
        end
        if (pop) begin
          completed_count <= completed_count + 16'd1;
          if (latency < lat_min) lat_min <= latency;
          if (latency > lat_max) lat_max <= latency;
          lat_sum <= sumWide[32] ? 32'hFFFF_FFFF : sumWide[31:0];
          if (headSize != resp_size_bytes) err_size_mismatch <= 1'b1;
        end
        if (resp_valid && (count_q == 5'd0)) err_unexpected_resp <= 1'b1;
      end
    end
  end

  // In-order tag FIFO of {issue stamp, size}; push on handshake, pop on response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= 5'd0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        stampMem_q[i] <= 32'd0;
        sizeMem_q[i]  <= '0;
      end
    end else begin
      if (handshake) begin
        stampMem_q[wrPtr_q] <= cycle_q;
        sizeMem_q[wrPtr_q]  <= sizeBytes_q;
        wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
      end
      if (pop) begin
        rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
      end
      case ({handshake, pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
